// File: rtl/core_if_ras.sv
// Return address stack for the IF stage: speculative push/pop from BTB predictions,
// with decode-issued one-cycle-late recovery applied ahead of the speculative op.
module core_if_ras #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              push,
  input  logic [31:0]       push_addr,
  input  logic              pop,
  input  logic              recover_push,
  input  logic [31:0]       recover_push_addr,
  input  logic              recover_pop,
  output logic [31:0]       top_addr,
  output logic              empty,
  output logic              full,
  output logic [PTR_W:0]    count
);

  localparam int DATA_W = 32;
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_ZERO = '0;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W:0]    r_count;

  logic              w_sp_push;
  logic              w_sp_pop;
  logic              w_rp;
  logic              w_rq;
  logic              w_cancel;
  logic              w_wa_en;
  logic [PTR_W-1:0]  w_wa_idx;
  logic [DATA_W-1:0] w_wa_data;
  logic              w_wb_en;
  logic [PTR_W-1:0]  w_wb_idx;
  logic [DATA_W-1:0] w_wb_data;
  logic [PTR_W-1:0]  w_ptr_mid;
  logic [PTR_W:0]    w_cnt_mid;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [PTR_W:0]    w_cnt_nxt;
  logic [PTR_W-1:0]  w_top_idx;

  function automatic logic [PTR_W:0] sat_inc(input logic [PTR_W:0] c);
    return (c == CNT_MAX) ? CNT_MAX : c + CNT_ONE;
  endfunction

  function automatic logic [PTR_W:0] sat_dec(input logic [PTR_W:0] c);
    return (c == CNT_ZERO) ? CNT_ZERO : c - CNT_ONE;
  endfunction

  // Operand qualification: push beats pop, recover_pop beats recover_push, flush kills speculation
  always_comb begin
    w_sp_push = push & ~flush;
    w_sp_pop  = pop & ~push & ~flush;
    w_rp      = recover_pop;
    w_rq      = recover_push & ~recover_pop;
    // A restore followed by a pop of the same entry nets to nothing, even at full
    w_cancel  = w_rq & w_sp_pop;
  end

  // Stage boundary: recovery (older instruction) applied to the registered state
  always_comb begin
    w_wa_en   = 1'b0;
    w_wa_idx  = r_ptr;
    w_wa_data = recover_push_addr;
    w_ptr_mid = r_ptr;
    w_cnt_mid = r_count;
    if (!w_cancel) begin
      if (w_rq) begin
        w_wa_en   = 1'b1;
        w_ptr_mid = r_ptr + PTR_ONE;
        w_cnt_mid = sat_inc(r_count);
      end else if (w_rp && (r_count != CNT_ZERO)) begin
        w_ptr_mid = r_ptr - PTR_ONE;
        w_cnt_mid = sat_dec(r_count);
      end
    end
  end

  // Stage boundary: speculative op (younger instruction) applied on top of recovery
  always_comb begin
    w_wb_en   = 1'b0;
    w_wb_idx  = w_ptr_mid;
    w_wb_data = push_addr;
    w_ptr_nxt = w_ptr_mid;
    w_cnt_nxt = w_cnt_mid;
    if (!w_cancel) begin
      if (w_sp_push) begin
        w_wb_en   = 1'b1;
        w_ptr_nxt = w_ptr_mid + PTR_ONE;
        w_cnt_nxt = sat_inc(w_cnt_mid);
      end else if (w_sp_pop && (w_cnt_mid != CNT_ZERO)) begin
        w_ptr_nxt = w_ptr_mid - PTR_ONE;
        w_cnt_nxt = sat_dec(w_cnt_mid);
      end
    end
  end

  // Stage boundary: state register, frozen while IF/ID is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (!stall) begin
      r_ptr   <= w_ptr_nxt;
      r_count <= w_cnt_nxt;
      if (w_wa_en) r_mem[w_wa_idx] <= w_wa_data;
      if (w_wb_en) r_mem[w_wb_idx] <= w_wb_data;
    end
  end

  assign w_top_idx = r_ptr - PTR_ONE;
  assign top_addr  = (r_count == CNT_ZERO) ? '0 : r_mem[w_top_idx];
  assign empty     = (r_count == CNT_ZERO);
  assign full      = (r_count == CNT_MAX);
  assign count     = r_count;

endmodule

// File: tb/tb_core_if_ras.sv
// Directed bench for core_if_ras: linear steps with hand-computed expectations.
module tb_core_if_ras;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        push;
  logic [31:0] push_addr;
  logic        pop;
  logic        recover_push;
  logic [31:0] recover_push_addr;
  logic        recover_pop;
  logic [31:0] top_addr;
  logic        empty;
  logic        full;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  core_if_ras #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .push(push), .push_addr(push_addr), .pop(pop),
    .recover_push(recover_push), .recover_push_addr(recover_push_addr),
    .recover_pop(recover_pop),
    .top_addr(top_addr), .empty(empty), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    push = 1'b0; push_addr = '0; pop = 1'b0;
    recover_push = 1'b0; recover_push_addr = '0; recover_pop = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] exp_top, input int exp_cnt);
    chk({tag, ".top"}, top_addr, exp_top);
    chk({tag, ".count"}, 32'(count), 32'(exp_cnt));
    chk({tag, ".empty"}, 32'(empty), (exp_cnt == 0) ? 32'd1 : 32'd0);
    chk({tag, ".full"}, 32'(full), (exp_cnt == 8) ? 32'd1 : 32'd0);
  endtask

  task automatic do_push(input logic [31:0] a);
    push = 1'b1; push_addr = a; tick(); push = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  // Fresh stack holding 0x100, 0x104 (top 0x104)
  task automatic setup2();
    do_reset(); do_push(32'h100); do_push(32'h104);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_state("reset", 32'h0, 0);

    // Basic LIFO
    do_push(32'h100); do_push(32'h104); do_push(32'h108);
    chk_state("push3", 32'h108, 3);
    pop = 1'b1;
    chk("pop1.pre", top_addr, 32'h108); tick();
    chk("pop2.pre", top_addr, 32'h104); tick();
    chk("pop3.pre", top_addr, 32'h100); tick();
    pop = 1'b0;
    chk_state("pop3.after", 32'h0, 0);

    // Overflow wraps and keeps the newest eight
    for (int i = 0; i < 10; i++) do_push(32'h100 + 32'(4 * i));
    chk_state("ovf", 32'h124, 8);
    pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf.pop", top_addr, 32'h124 - 32'(4 * i));
      tick();
    end
    chk_state("ovf.drained", 32'h0, 0);
    tick();
    pop = 1'b0;
    chk_state("underflow", 32'h0, 0);
    do_push(32'h200);
    chk_state("after.underflow", 32'h200, 1);

    // recover_pop + push at count 2
    setup2();
    chk_state("setup2", 32'h104, 2);
    recover_pop = 1'b1; push = 1'b1; push_addr = 32'h300; tick(); idle();
    chk_state("rp.push", 32'h300, 2);
    pop = 1'b1; tick(); pop = 1'b0;
    chk_state("rp.push.pop", 32'h100, 1);

    // recover_push + pop cancels
    setup2();
    recover_push = 1'b1; recover_push_addr = 32'h500; pop = 1'b1; tick(); idle();
    chk_state("rq.pop", 32'h104, 2);

    // recover_push + push lands two entries
    setup2();
    recover_push = 1'b1; recover_push_addr = 32'h500; push = 1'b1; push_addr = 32'h600;
    tick(); idle();
    chk_state("rq.push", 32'h600, 4);
    pop = 1'b1; tick(); pop = 1'b0;
    chk_state("rq.push.pop", 32'h500, 3);

    // recover_pop + pop at count 1 drains to empty
    do_reset(); do_push(32'hC00);
    recover_pop = 1'b1; pop = 1'b1; tick(); idle();
    chk_state("rp.pop.c1", 32'h0, 0);

    // Stall freezes everything; release applies the held ops once
    setup2();
    stall = 1'b1; push = 1'b1; push_addr = 32'h700; recover_pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("stall", 32'h104, 2);
    end
    stall = 1'b0; tick(); idle();
    chk_state("stall.release", 32'h700, 2);
    tick();
    chk_state("stall.once", 32'h700, 2);

    // Flush drops the speculative push but keeps the recovery
    flush = 1'b1; push = 1'b1; push_addr = 32'h800;
    recover_push = 1'b1; recover_push_addr = 32'h900; tick(); idle();
    chk_state("flush", 32'h900, 3);

    // Reset mid-sequence overrides an active push
    do_push(32'hA00); do_push(32'hB00);
    chk_state("pre.rst", 32'hB00, 5);
    rst = 1'b1; push = 1'b1; push_addr = 32'hD00; tick(); idle();
    chk_state("mid.rst", 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core_if_ras.md
# core_if_ras

Return address stack (RAS) for the IF stage of each core. It speculatively pushes return addresses on predicted `jal` and pops them on predicted `jr`, and supplies `top_addr` as the predicted `jr` target. It applies the one-cycle-late `recover_push`/`recover_pop` corrections that the decode stage issues when an IF-time BTB prediction of call/return type turns out wrong. It sits beside the BTB/PHT in IF, directly upstream of decode, and consumes decode's recovery outputs.

## Interface
- `DEPTH`, 8, number of entries; must be a power of two, ≥2.
- `PTR_W`, 3, log2(`DEPTH`).

Ports:
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  IF/ID held (alu or branch hazard stall); freezes all state.
- `flush`  in  1  decode `if_flush`; suppresses this cycle's speculative op.
- `push`  in  1  IF predicted `jal` (BTB hit, jal type).
- `push_addr`  in  32  return address to push (`pc + 4` of the `jal`).
- `pop`  in  1  IF predicted `jr` (BTB hit, jr type).
- `recover_push`  in  1  decode: undo an erroneous pop.
- `recover_push_addr`  in  32  address to restore.
- `recover_pop`  in  1  decode: undo an erroneous push.
- `top_addr`  out  32  current top entry; 0 when empty.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `count`  out  `PTR_W+1`  number of valid entries.

## Operation
- State:
  - `mem[DEPTH]` of 32 bits each.
  - `ptr` (`PTR_W` bits): next write slot; the top entry is `mem[ptr-1]`, modulo `DEPTH`.
  - `count` (`PTR_W+1` bits).
- Operand qualification:
  - Speculative op: `sp = push` or `sp_pop = pop & !push`. Push wins if both are asserted. Both are ignored when `flush`.
  - Recovery op: `rp = recover_pop` or `rq = recover_push & !recover_pop`. Pop wins if both are asserted.
  - When `stall` is high, no state changes. Decode holds its instruction, so its recovery re-presents after the stall.
- Order: recovery (older instruction) is applied first, then the speculative op (younger instruction), within one edge.
- Single ops:
  - Push: `mem[ptr] <= addr`; `ptr+1`; `count = min(count+1, DEPTH)`. At full, the oldest entry is overwritten; it is a circular buffer.
  - Pop: if `count > 0`, `ptr-1` and `count-1`. If `count == 0`, no change (underflow ignored).
- Combined cases, with recovery listed first:
  - `rq` + push: `mem[ptr] = recover_push_addr`, `mem[ptr+1] = push_addr`; `ptr+2`; `count = min(count+2, DEPTH)`.
  - `rq` + pop: no state change (the restored entry is immediately consumed).
  - `rp` + push, `count > 0`: `mem[ptr-1] = push_addr`; `ptr` and `count` unchanged.
  - `rp` + push, `count == 0`: ordinary push.
  - `rp` + pop: `count ≥ 2`: `ptr-2`, `count-2`. `count == 1`: `ptr-1`, `count = 0`. `count == 0`: no change.
- All pointer arithmetic is modulo `DEPTH`. `count` saturates at `DEPTH` and at 0.
- Outputs are combinational from registered state:
  - `top_addr = (count == 0) ? 0 : mem[ptr-1]`.
  - `empty`, `full` and `count` follow `count` directly.
- Reset: `ptr = 0`, `count = 0`, all `mem` entries 0. Therefore `top_addr = 0`, `empty = 1`, `full = 0`, `count = 0`. Reset overrides every other input, including mid-stall.

## Timing
- Single clock domain; no handshake; inputs are sampled at the rising edge.
- A push at edge k is visible on `top_addr` after edge k (1-cycle latency). A pop in the same cycle sees the pre-edge top.
- A `pop` in cycle k uses `top_addr` from the pre-edge state. This holds even when a recovery is applied at the same edge.
- `stall` and `flush` are level-sensitive for that cycle only.
- No combinational path from any input to any output.

## Test plan
- Reset, then push `0x100`, `0x104`, `0x108` on consecutive cycles → `count = 3`, `top_addr = 0x108`. Then three pops → `top_addr` reads `0x108`, `0x104`, `0x100` before each respective edge; afterwards `empty = 1`, `top_addr = 0`.
- Overflow: push 10 addresses, `0x100` to `0x124` step 4 → `full = 1`, `count = 8`, `top_addr = 0x124`. Then 8 pops yield `0x124` down to `0x108`; the ninth pop leaves `count = 0` with no change.
- Underflow: pop at `count = 0` → `count` stays 0, `ptr` unchanged. A following push of `0x200` gives `top_addr = 0x200`, `count = 1`.
- Simultaneous ops at `count = 2` (top `0x104`):
  - `recover_pop` + push `0x300` → `count = 2`, `top_addr = 0x300`.
  - `recover_push 0x500` + pop → state unchanged.
  - `recover_push 0x500` + push `0x600` → `count = 4`, top `0x600`; next pop exposes `0x500`.
- `stall = 1` with push `0x700` and `recover_pop` held for 3 cycles → no change. Release stall → both are applied once.
- `flush = 1` with push `0x800` and `recover_push 0x900` → only the recovery is applied: `top_addr = 0x900`, `count` increments by 1.
- Assert `rst` mid-sequence with `count = 5` → next cycle: `count = 0`, `empty = 1`, `top_addr = 0`.
